// File: rtl/sha_mem_responder.sv
// Single-port word RAM shared between the host and the SHA-256 engine, with run
// sequencing, digest-write snooping, sticky error flags and saturating access counters.
module sha_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         host_we,
  input  logic [15:0]  host_addr,
  input  logic [31:0]  host_wdata,
  output logic [31:0]  host_rdata,
  input  logic         go,
  input  logic [15:0]  msg_base,
  input  logic [15:0]  out_base,
  output logic         eng_start,
  output logic [15:0]  eng_message_addr,
  output logic [15:0]  eng_output_addr,
  input  logic         eng_done,
  input  logic         eng_mem_we,
  input  logic [15:0]  eng_mem_addr,
  input  logic [31:0]  eng_mem_write_data,
  output logic [31:0]  eng_mem_read_data,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         err_oor,
  output logic         err_incomplete,
  output logic [15:0]  read_count,
  output logic [7:0]   write_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [TW-1:0] tcnt;
  logic [7:0]    mask;

  logic          run;
  logic          ram_we;
  logic          in_range;
  logic [15:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rd;
  logic [15:0]   snoop_off;
  logic          snoop_hit;
  logic [7:0]    mask_next;
  logic          tmo;

  // One physical port: the engine owns it in RUN, the host in IDLE, nobody in START.
  assign run       = (state == RUN);
  assign ram_addr  = run ? eng_mem_addr : host_addr;
  assign ram_wdata = run ? eng_mem_write_data : host_wdata;
  assign ram_we    = run ? eng_mem_we : ((state == IDLE) && host_we);
  assign in_range  = ({16'd0, ram_addr} < 32'(DEPTH));
  assign ram_rd    = in_range ? mem[ram_addr[AW-1:0]] : 32'h0;

  // Wrapping subtraction lets a digest window straddle address 16'hFFFF.
  assign snoop_off = eng_mem_addr - eng_output_addr;
  assign snoop_hit = eng_mem_we && (snoop_off < 16'd8);
  assign mask_next = mask | (snoop_hit ? (8'd1 << snoop_off[2:0]) : 8'd0);
  assign tmo       = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (ram_we && in_range) mem[ram_addr[AW-1:0]] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      eng_start         <= 1'b0;
      eng_message_addr  <= '0;
      eng_output_addr   <= '0;
      busy              <= 1'b0;
      digest_valid      <= 1'b0;
      digest            <= '0;
      mask              <= '0;
      err_oor           <= 1'b0;
      err_incomplete    <= 1'b0;
      read_count        <= '0;
      write_count       <= '0;
      tcnt              <= '0;
      host_rdata        <= '0;
      eng_mem_read_data <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          host_rdata <= ram_rd;
          if (go) begin
            eng_message_addr <= msg_base;
            eng_output_addr  <= out_base;
            digest           <= '0;
            mask             <= '0;
            read_count       <= '0;
            write_count      <= '0;
            err_oor          <= 1'b0;
            err_incomplete   <= 1'b0;
            digest_valid     <= 1'b0;
            busy             <= 1'b1;
            eng_start        <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          tcnt  <= '0;
          state <= RUN;
        end
        RUN: begin
          eng_mem_read_data <= ram_rd;
          if (eng_mem_we) begin
            if (write_count != 8'hFF) write_count <= write_count + 8'd1;
          end else if (read_count != 16'hFFFF) begin
            read_count <= read_count + 16'd1;
          end
          if (!in_range) err_oor <= 1'b1;
          mask <= mask_next;
          for (int i = 0; i < 8; i++) begin
            if (snoop_hit && (snoop_off[2:0] == 3'(i)))
              digest[(7-i)*32 +: 32] <= eng_mem_write_data;
          end
          tcnt <= tcnt + TW'(1);
          if (eng_done) begin
            digest_valid <= (mask_next == 8'hFF);
            if (mask_next != 8'hFF) err_incomplete <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tmo) begin
            err_incomplete <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed and randomized bench for sha_mem_responder with an array/queue reference model.
module tb_sha_mem_responder;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 512;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         host_we = 1'b0;
  logic [15:0]  host_addr = '0;
  logic [31:0]  host_wdata = '0;
  logic [31:0]  host_rdata;
  logic         go = 1'b0;
  logic [15:0]  msg_base = '0;
  logic [15:0]  out_base = '0;
  logic         eng_start;
  logic [15:0]  eng_message_addr;
  logic [15:0]  eng_output_addr;
  logic         eng_done = 1'b0;
  logic         eng_mem_we = 1'b0;
  logic [15:0]  eng_mem_addr = '0;
  logic [31:0]  eng_mem_write_data = '0;
  logic [31:0]  eng_mem_read_data;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;
  logic         err_oor;
  logic         err_incomplete;
  logic [15:0]  read_count;
  logic [7:0]   write_count;

  sha_mem_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .go(go), .msg_base(msg_base), .out_base(out_base),
    .eng_start(eng_start), .eng_message_addr(eng_message_addr), .eng_output_addr(eng_output_addr),
    .eng_done(eng_done), .eng_mem_we(eng_mem_we), .eng_mem_addr(eng_mem_addr),
    .eng_mem_write_data(eng_mem_write_data), .eng_mem_read_data(eng_mem_read_data),
    .busy(busy), .digest_valid(digest_valid), .digest(digest),
    .err_oor(err_oor), .err_incomplete(err_incomplete),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Reference model: memory image plus per-run bookkeeping.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_dig [8];
  logic [7:0]  m_mask;
  int          m_rd, m_wr;
  logic        m_oor, m_valid, m_inc;
  logic [15:0] m_out;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    if (int'(a) < DEPTH) return ref_mem[int'(a)];
    return 32'h0;
  endfunction

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
    if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
  endtask

  task automatic host_read(input string tag, input logic [15:0] a);
    host_addr = a;
    tick();
    check(tag, 256'(host_rdata), 256'(ref_rd(a)));
  endtask

  // Returns with the DUT in RUN, ready for the first engine access.
  task automatic launch(input logic [15:0] msg, input logic [15:0] outb);
    go = 1'b1; msg_base = msg; out_base = outb;
    tick();
    go = 1'b0;
    m_mask = '0; m_rd = 0; m_wr = 0; m_oor = 1'b0; m_valid = 1'b0; m_inc = 1'b0; m_out = outb;
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    check("start_pulse", 256'(eng_start), 256'(1));
    check("busy_on_go", 256'(busy), 256'(1));
    check("go_clears", 256'({digest_valid, err_incomplete, err_oor}), 256'(0));
    check("bases", 256'({eng_message_addr, eng_output_addr}), 256'({msg, outb}));
    tick();
    check("start_one_cycle", 256'(eng_start), 256'(0));
  endtask

  task automatic eng_step(input logic we, input logic [15:0] a, input logic [31:0] d, input logic done);
    logic [31:0] exp_rd;
    logic [15:0] idx;
    exp_rd = ref_rd(a);
    eng_mem_we = we; eng_mem_addr = a; eng_mem_write_data = d; eng_done = done;
    tick();
    eng_mem_we = 1'b0; eng_done = 1'b0;
    if (int'(a) >= DEPTH) m_oor = 1'b1;
    idx = a - m_out;
    if (we) begin
      if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
      if (m_wr < 255) m_wr++;
      if (int'(idx) < 8) begin
        m_dig[int'(idx)] = d;
        m_mask[int'(idx)] = 1'b1;
      end
    end else begin
      if (m_rd < 65535) m_rd++;
      check("eng_rdata", 256'(eng_mem_read_data), 256'(exp_rd));
    end
    if (done) begin
      if (m_mask == 8'hFF) m_valid = 1'b1;
      else m_inc = 1'b1;
    end
  endtask

  task automatic check_run();
    check("busy_end", 256'(busy), 256'(0));
    check("digest_valid", 256'(digest_valid), 256'(m_valid));
    check("digest", digest, {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_dig[5], m_dig[6], m_dig[7]});
    check("errors", 256'({err_oor, err_incomplete}), 256'({m_oor, m_inc}));
    check("read_count", 256'(read_count), 256'(m_rd));
    check("write_count", 256'(write_count), 256'(m_wr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 256'({busy, eng_start, digest_valid, err_oor, err_incomplete}), 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
    check({tag, "_counts"}, 256'({read_count, write_count}), 256'(0));
    check({tag, "_data"}, 256'({host_rdata, eng_mem_read_data}), 256'(0));
    check({tag, "_addrs"}, 256'({eng_message_addr, eng_output_addr}), 256'(0));
  endtask

  initial begin
    logic [255:0] exp_dig;
    logic [15:0]  outb, a;
    int           k, n;

    tick(); tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // Load: whole RAM randomized, then the known message words.
    for (int i = 0; i < DEPTH; i++) host_write(16'(i), $urandom);
    for (int i = 0; i < 20; i++) host_write(16'(i), 32'hA000_0000 + 32'(i));
    host_read("host_read5", 16'd5);
    check("host_read5_const", 256'(host_rdata), 256'(32'hA000_0005));
    host_read("host_read_oor", 16'h0300);

    // Engine reads 0..19, done on the last read.
    launch(16'h0000, 16'h0080);
    for (int i = 0; i < 20; i++) eng_step(1'b0, 16'(i), 32'h0, i == 19);
    check_run();
    check("read_count20", 256'(read_count), 256'(20));

    // Complete digest capture, done alongside the last write.
    launch(16'h0000, 16'h0080);
    for (int i = 0; i < 8; i++) eng_step(1'b1, 16'h0080 + 16'(i), 32'h1000_0000 + 32'(i), i == 7);
    check_run();
    for (int i = 0; i < 8; i++) exp_dig[(7-i)*32 +: 32] = 32'h1000_0000 + 32'(i);
    check("digest_const", digest, exp_dig);
    check("valid_wc8", 256'({digest_valid, write_count}), 256'({1'b1, 8'd8}));
    host_read("ram_0083", 16'h0083);
    check("ram_0083_const", 256'(host_rdata), 256'(32'h1000_0003));
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("done_in_idle", 256'({busy, digest_valid, err_incomplete}), 256'({1'b0, 1'b1, 1'b0}));

    // Seven digest words only.
    launch(16'h0000, 16'h0080);
    for (int i = 0; i < 7; i++) eng_step(1'b1, 16'h0080 + 16'(i), $urandom, 1'b0);
    eng_step(1'b0, 16'h0000, 32'h0, 1'b1);
    check_run();

    // Out-of-range read, dropped host write, ignored go, then timeout.
    launch(16'h0010, 16'h0040);
    eng_step(1'b0, 16'h0100, 32'h0, 1'b0);
    check("oor_flag", 256'(err_oor), 256'(1));
    host_we = 1'b1; host_addr = 16'h0003; host_wdata = ~ref_mem[3];
    go = 1'b1; msg_base = 16'h0055; out_base = 16'h0066;
    eng_step(1'b0, 16'h0002, 32'h0, 1'b0);
    host_we = 1'b0; go = 1'b0;
    check("no_second_start", 256'(eng_start), 256'(0));
    check("bases_held", 256'({eng_message_addr, eng_output_addr}), 256'({16'h0010, 16'h0040}));
    k = 2;
    while (busy && k < TIMEOUT + 8) begin
      if (k == TIMEOUT - 1) check("busy_before_tmo", 256'(busy), 256'(1));
      tick();
      k++;
    end
    check("timeout_cycles", 256'(k), 256'(TIMEOUT));
    m_rd = TIMEOUT; m_inc = 1'b1;
    check_run();
    host_read("run_write_dropped", 16'h0003);

    // Write counter saturation.
    launch(16'h0000, 16'h0080);
    for (int i = 0; i < 260; i++) eng_step(1'b1, 16'h0010, 32'(i), i == 259);
    check_run();
    check("wc_saturated", 256'(write_count), 256'(8'hFF));

    // Randomized runs; the first places the digest window across the 16-bit wrap.
    for (int r = 0; r < 8; r++) begin
      outb = (r == 0) ? 16'hFFFC : 16'($urandom_range(0, 270));
      launch(16'($urandom_range(0, 255)), outb);
      if (r % 2 == 1)
        for (int i = 0; i < 8; i++) eng_step(1'b1, outb + 16'(i), $urandom, 1'b0);
      n = $urandom_range(5, 30);
      for (int s = 0; s < n; s++) begin
        if ($urandom_range(0, 1) == 1)
          eng_step(1'b1, outb + 16'($urandom_range(0, 9)), $urandom, s == n - 1);
        else
          eng_step(1'b0, 16'($urandom_range(0, 300)), 32'h0, s == n - 1);
      end
      check_run();
      for (int j = 0; j < 3; j++) begin
        a = (j == 0) ? outb : 16'($urandom_range(0, 300));
        host_read("rand_readback", a);
      end
    end

    // Asynchronous reset in the middle of a run.
    launch(16'h0001, 16'h0080);
    eng_step(1'b1, 16'h0080, 32'hCAFE_F00D, 1'b0);
    eng_step(1'b0, 16'h0004, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", 256'(busy), 256'(0));
    launch(16'h0000, 16'h0080);
    eng_step(1'b0, 16'h0200, 32'h0, 1'b1);
    check_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
# sha_mem_responder

Memory-side responder for the SHA-256 engine's word-memory interface. Owns a synthesizable single-port word RAM that serves engine reads and absorbs its digest writes. Host side: load the message, launch the engine with a one-cycle `start` pulse, capture the eight digest words as they are written, and report completion, errors and access counts. Sits between the host/bench and the hashing core in place of a behavioural memory model.

## Interface
Parameters:
- `DEPTH`, 256: RAM size in 32-bit words; valid addresses are 0..DEPTH-1.
- `TIMEOUT`, 4096: maximum RUN cycles allowed before the engine's `done` is seen.

Ports:
- `clk`  in  1  clock; the engine's `mem_clk` equals `clk`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `host_we`  in  1  host write strobe; ignored while `busy`.
- `host_addr`  in  16  host word address.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  registered host read data.
- `go`  in  1  launch pulse; ignored while `busy`.
- `msg_base`  in  16  message start address; latched on `go`.
- `out_base`  in  16  digest start address; latched on `go`.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_message_addr`  out  16  latched `msg_base`.
- `eng_output_addr`  out  16  latched `out_base`.
- `eng_done`  in  1  engine done pulse.
- `eng_mem_we`  in  1  engine write enable.
- `eng_mem_addr`  in  16  engine word address.
- `eng_mem_write_data`  in  32  engine write data.
- `eng_mem_read_data`  out  32  registered read data to the engine.
- `busy`  out  1  high from `go` accepted until return to IDLE.
- `digest_valid`  out  1  captured digest complete; held until next `go`.
- `digest`  out  256  captured digest, {h0..h7}; h0 in [255:224].
- `err_oor`  out  1  sticky out-of-range access; cleared on `go`.
- `err_incomplete`  out  1  sticky: done without all 8 digest words, or timeout; cleared on `go`.
- `read_count`  out  16  engine reads during the current run, saturating.
- `write_count`  out  8  engine writes during the current run, saturating.

## Operation
- States: IDLE, START, RUN.
- **IDLE**
  - The host owns the RAM port.
  - `host_we` writes `host_wdata` to `host_addr`.
  - Every cycle, `host_rdata` is loaded with RAM[`host_addr`].
  - On `go`, in the same cycle:
    - latch `msg_base` and `out_base`;
    - clear the digest, the 8-bit written mask, both counters, both errors and `digest_valid`;
    - set `busy`;
    - move to START.
- **START**
  - `eng_start` is 1 for this single cycle.
  - Move to RUN and clear the timeout counter.
- **RUN**
  - The engine owns the RAM port.
  - Host writes are dropped; `host_rdata` holds its last value.
  - Each cycle, `eng_mem_read_data` is loaded with RAM[`eng_mem_addr`].
  - When `eng_mem_we` = 1:
    - RAM[`eng_mem_addr`] <= `eng_mem_write_data`;
    - `write_count` increments.
  - When `eng_mem_we` = 0, `read_count` increments.
  - Digest snoop: a write with `eng_mem_addr` − `out_base` = idx, where 0 ≤ idx ≤ 7 (16-bit unsigned subtraction), stores the data in digest word idx and sets mask bit idx. A rewrite of the same idx overwrites.
  - On `eng_done`:
    - `digest_valid` <= (mask == 8'hFF), evaluated including a write in the same cycle;
    - otherwise `err_incomplete` <= 1;
    - move to IDLE and clear `busy`.
  - If the timeout counter reaches `TIMEOUT` first: `err_incomplete` <= 1, move to IDLE, clear `busy`.
- **Out-of-range access** (address ≥ DEPTH, from either port)
  - Reads return 32'h0.
  - Writes are dropped.
  - A host access does not set `err_oor`; it is reported only for engine accesses.
  - An engine access sets `err_oor` and is still counted.
- Counters saturate at all-ones.

## Timing
- Reset: all outputs 0, state IDLE, RAM contents undefined.
- Reset asserted mid-run aborts immediately; after release the block is IDLE with `busy` = 0.
- Read latency is 1 cycle on both ports: data for the address presented at edge N is valid after edge N+1.
- A write is visible to a read of the same address on the following cycle. A same-cycle read of a written address returns the old data.
- `go` → `eng_start` high after 1 edge; `busy` high after the same edge.
- `eng_done` → `busy` low and `digest_valid` updated after 1 edge.
- `go` while `busy` is ignored. `eng_done` outside RUN is ignored.

## Test plan
- **Load and read back:** host writes words 0..19 = 32'hA000_0000+i, then reads address 5 → `host_rdata` = 32'hA000_0005 one cycle later.
- **Engine reads:** with the engine stub reading addresses 0..19 → `eng_mem_read_data` = 32'hA000_0000+i, one cycle after each address; `read_count` = 20.
- **Digest capture:** `out_base` = 16'h0080; stub writes 32'h1000_0000+i to 16'h0080+i (i = 0..7), then pulses done.
  - Required: `digest` = {32'h1000_0000 .. 32'h1000_0007}, `digest_valid` = 1, `write_count` = 8, `busy` = 0.
  - RAM[16'h0083] reads 32'h1000_0003.
- **Incomplete digest:** stub writes only 7 digest words, then done → `digest_valid` = 0, `err_incomplete` = 1. The next `go` clears both.
- **Out of range and timeout:**
  - Stub reads 16'h0100 with DEPTH = 256 → data 0, `err_oor` = 1.
  - Stub never raises done → `err_incomplete` = 1 and `busy` = 0 after TIMEOUT+2 cycles from `go`.
- **Reset mid-run and ownership:**
  - Assert `reset_n` = 0 during RUN → all outputs 0.
  - `host_we` during RUN leaves RAM unchanged.
  - A second `go` during RUN produces no second `eng_start`.
